// File: rtl/mac_pkg.sv
// Shared definitions for the MAC back end: chunk width, sequencer states
// and a helper sizing the chunk index.
package mac_pkg;

    localparam int CHUNK_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int idx_w(input int nchunk);
        int w;
        w = 1;
        while ((1 << w) < nchunk) w++;
        return w;
    endfunction

endpackage

// File: rtl/adder_6bit.sv
// 6-bit carry-select adder slice: low half ripples, high half is
// precomputed for both carry values and selected by the low carry.
module adder_6bit
    import mac_pkg::*;
(
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] s,
    output logic               co
);

    localparam int HALF = CHUNK_W / 2;

    logic [HALF:0] lo;
    logic [HALF:0] hi0;
    logic [HALF:0] hi1;
    logic [HALF:0] hi;

    always_comb begin
        lo  = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]}
            + {{HALF{1'b0}}, cin};
        hi0 = {1'b0, a[CHUNK_W-1:HALF]} + {1'b0, b[CHUNK_W-1:HALF]};
        hi1 = {1'b0, a[CHUNK_W-1:HALF]} + {1'b0, b[CHUNK_W-1:HALF]}
            + {{HALF{1'b0}}, 1'b1};
        hi  = lo[HALF] ? hi1 : hi0;
        s   = {hi[HALF-1:0], lo[HALF-1:0]};
        co  = hi[HALF];
    end

endmodule

// File: rtl/adder6_seq_accum.sv
// Wide adder/accumulator that reuses one 6-bit slice across all chunks,
// one chunk per cycle, with the inter-chunk carry held in a register.
module adder6_seq_accum
    import mac_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             acc_en,
    input  logic             clr_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK_W;
    localparam int IDX_W  = idx_w(NCHUNK);

    if ((WIDTH % CHUNK_W) != 0 || WIDTH < CHUNK_W) begin : g_bad_width
        $error("adder6_seq_accum: WIDTH must be a non-zero multiple of 6");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic [CHUNK_W-1:0] s_chunk;
    logic               s_co;
    logic [WIDTH-1:0]   res_ins;
    logic               last;

    adder_6bit u_slice (
        .a   (a_chunk),
        .b   (b_chunk),
        .cin (carry_q),
        .s   (s_chunk),
        .co  (s_co)
    );

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        res_ins = res_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_chunk = a_q[i*CHUNK_W +: CHUNK_W];
                b_chunk = b_q[i*CHUNK_W +: CHUNK_W];
                res_ins[i*CHUNK_W +: CHUNK_W] = s_chunk;
            end
        end
        last = (idx_q == IDX_W'(NCHUNK - 1));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (clr_acc) acc_d = '0;
                if (in_valid) begin
                    // A clear alongside an accumulate makes B zero.
                    a_d     = op_a;
                    b_d     = acc_en ? (clr_acc ? '0 : acc_q) : op_b;
                    mode_d  = acc_en;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = res_ins;
                carry_d = s_co;
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    idx_d   = '0;
                    cout_d  = s_co;
                    sum_d   = res_ins;
                    state_d = DONE;
                    if (mode_q) acc_d = res_ins;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
